// File: rtl/dot_product_accum.sv
// Dot-product accumulator: sums every k_len consecutive unsigned products and
// emits n_dots results per job over a valid/ready port, back-pressuring upstream.
module dot_product_accum #(
  parameter int PROD_WIDTH = 26,
  parameter int ACC_WIDTH  = 36,
  parameter int KW         = 10,
  parameter int NW         = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic [NW-1:0]         n_dots,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [KW-1:0]        k_len_q, k_cnt;
  logic [NW-1:0]        n_dots_q, d_cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;
  logic                 beat, last_beat, last_dot, drain_exit, start_zero, done_next;

  // One extra bit holds the carry-out that feeds the sticky overflow flag.
  assign sum        = {1'b0, acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, in_data};
  assign busy       = (state != IDLE);
  assign in_ready   = (state == ACCUM) && (!out_valid || out_ready);
  assign beat       = in_valid && in_ready;
  assign last_beat  = (k_cnt == k_len_q - 1'b1);
  assign last_dot   = (d_cnt == n_dots_q - 1'b1);
  assign start_zero = (k_len == '0) || (n_dots == '0);
  assign drain_exit = (state == DRAIN) && (!out_valid || out_ready);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (start_zero) done_next  = 1'b1;
          else            state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (beat && last_beat && last_dot) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_exit) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      acc       <= '0;
      k_cnt     <= '0;
      d_cnt     <= '0;
      k_len_q   <= '0;
      n_dots_q  <= '0;
    end else begin
      done <= done_next;

      if (state == IDLE && start) begin
        k_len_q  <= k_len;
        n_dots_q <= n_dots;
        overflow <= 1'b0;
        acc      <= '0;
        k_cnt    <= '0;
        d_cnt    <= '0;
      end

      // A load in the same cycle as a handshake overrides the clear below.
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (beat) begin
        if (sum[ACC_WIDTH]) overflow <= 1'b1;
        if (last_beat) begin
          out_data  <= sum[ACC_WIDTH-1:0];
          out_valid <= 1'b1;
          acc       <= '0;
          k_cnt     <= '0;
          d_cnt     <= d_cnt + 1'b1;
        end else begin
          acc   <= sum[ACC_WIDTH-1:0];
          k_cnt <= k_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_accum.sv
// Self-checking bench for dot_product_accum: table-driven jobs with a result
// scoreboard, plus hand sequences for stall, reset, zero-length and overflow.
module tb_dot_product_accum;

  localparam int PW = 26;
  localparam int AW = 36;
  localparam int KW = 10;
  localparam int NW = 16;

  typedef struct {
    int              k;
    int              n;
    int              base;
    int              step;
    int              mode;       // 0: out_ready high, 1: random out_ready
    longint unsigned exp_first;
    logic            exp_ovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [NW-1:0] n_dots = '0;
  logic          busy, done, in_ready, out_valid, overflow;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_data;

  logic          o_start = 1'b0;
  logic [KW-1:0] o_k_len = '0;
  logic [NW-1:0] o_n_dots = '0;
  logic          o_busy, o_done, o_in_ready, o_out_valid, o_overflow;
  logic          o_in_valid = 1'b0;
  logic [PW-1:0] o_in_data = '0;
  logic          o_out_ready = 1'b1;
  logic [PW-1:0] o_out_data;

  dot_product_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .KW(KW), .NW(NW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len), .n_dots(n_dots),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .overflow(overflow)
  );

  // Narrow accumulator instance to exercise wrap-around and the overflow flag.
  dot_product_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(PW), .KW(KW), .NW(NW)) dut_ovf (
    .clk(clk), .reset_n(reset_n), .start(o_start), .k_len(o_k_len), .n_dots(o_n_dots),
    .busy(o_busy), .done(o_done), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_data(o_in_data), .out_valid(o_out_valid), .out_ready(o_out_ready),
    .out_data(o_out_data), .overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail = 0;
  longint unsigned exp_q[$];
  longint unsigned out_log[$];
  logic [PW-1:0]   stim_q[$];
  int              done_cnt = 0;
  bit              hold_pending = 1'b0;
  logic [AW-1:0]   hold_data = '0;
  bit              prev_done = 1'b0;
  bit              prev_hs = 1'b0;
  bit              job_has_results = 1'b0;
  vec_t            vecs[6];

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Output monitor: sampled mid-cycle, after the driver has settled its inputs.
  always @(negedge clk) begin
    #2;
    if (hold_pending) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, hold_data);
    end
    hold_pending = out_valid && !out_ready;
    hold_data    = out_data;
    if (done) begin
      check("done_one_cycle", prev_done, 0);
      if (job_has_results) check("done_after_handshake", prev_hs, 1);
      done_cnt++;
    end
    if (out_valid && out_ready) begin
      out_log.push_back(out_data);
      if (exp_q.size() == 0) check("spurious_result", exp_q.size(), 1);
      else check("result", out_data, exp_q.pop_front());
    end
    prev_hs   = out_valid && out_ready;
    prev_done = done;
  end

  // Runs one job on the main DUT using the beats in stim_q.
  task automatic run_job(input int k, input int n, input int mode,
                         input longint unsigned exp_first, input logic exp_ovf);
    int              total;
    int              i;
    int              cyc;
    int              stalls;
    int              hs0;
    int              done0;
    longint unsigned sum;
    total  = k * n;
    i      = 0;
    cyc    = 0;
    stalls = 0;
    hs0    = out_log.size();
    done0  = done_cnt;
    for (int d = 0; d < n; d++) begin
      sum = 0;
      for (int j = 0; j < k; j++) sum += stim_q[d * k + j];
      exp_q.push_back(sum & ((64'd1 << AW) - 1));
    end
    job_has_results = 1'b1;
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); n_dots = NW'(n); out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", busy, 1);
    check("in_ready_after_start", in_ready, 1);
    check("overflow_cleared", overflow, 0);
    while ((i < total || done_cnt == done0) && cyc < 20000) begin
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (out_log.size() == hs0) || (stalls >= 5);
        default: out_ready = 1'b1;
      endcase
      in_valid = (i < total);
      in_data  = (i < total) ? stim_q[i] : '0;
      #1;
      if (mode == 0 && i < total) check("in_ready_no_bubble", in_ready, 1);
      if (mode == 2 && !out_ready && out_valid) begin
        stalls++;
        check("stall_in_ready", in_ready, 0);
        check("stall_data", out_data, 7);
      end
      if (in_valid && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20000) check("job_timeout", cyc, 0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("result_count", out_log.size() - hs0, n);
    if (out_log.size() > hs0) check("first_result", out_log[hs0], exp_first);
    check("overflow_end", overflow, exp_ovf);
    check("busy_end", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
    stim_q.delete();
  endtask

  initial begin
    vecs = '{
      '{k: 2,    n: 3, base: 1,        step: 1, mode: 0, exp_first: 3,               exp_ovf: 1'b0},
      '{k: 2,    n: 3, base: 1,        step: 1, mode: 1, exp_first: 3,               exp_ovf: 1'b0},
      '{k: 1,    n: 4, base: 100,      step: 1, mode: 0, exp_first: 100,             exp_ovf: 1'b0},
      '{k: 5,    n: 2, base: 0,        step: 1, mode: 1, exp_first: 10,              exp_ovf: 1'b0},
      '{k: 4,    n: 3, base: 1000,     step: 1, mode: 1, exp_first: 4006,            exp_ovf: 1'b0},
      '{k: 1023, n: 1, base: 67108863, step: 0, mode: 1, exp_first: 64'd68652366849, exp_ovf: 1'b0}
    };

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single dot product: 5 + 7 + 11.
    stim_q = '{26'd5, 26'd7, 26'd11};
    run_job(3, 1, 0, 23, 1'b0);

    // Downstream stall after the first result.
    for (int i = 1; i <= 6; i++) stim_q.push_back(PW'(i));
    run_job(2, 3, 2, 3, 1'b0);

    // Table-driven jobs.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].k * vecs[v].n; i++)
        stim_q.push_back(PW'(vecs[v].base + i * vecs[v].step));
      run_job(vecs[v].k, vecs[v].n, vecs[v].mode, vecs[v].exp_first, vecs[v].exp_ovf);
    end

    // Reset after 2 of 4 beats aborts the job.
    job_has_results = 1'b0;
    @(negedge clk);
    start = 1'b1; k_len = 10'd4; n_dots = 16'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 26'd9;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    stim_q = '{26'd1, 26'd1, 26'd1, 26'd1};
    run_job(4, 1, 0, 4, 1'b0);

    // Zero-length jobs: done next cycle, no result.
    for (int z = 0; z < 2; z++) begin
      job_has_results = 1'b0;
      @(negedge clk);
      start = 1'b1; k_len = (z == 0) ? 10'd0 : 10'd3; n_dots = (z == 0) ? 16'd5 : 16'd0;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_out_valid", out_valid, 0);
      @(negedge clk);
      #1;
      check("zero_done_fall", done, 0);
      check("zero_out_valid_after", out_valid, 0);
    end

    // Narrow accumulator wraps and flags overflow.
    @(negedge clk);
    o_start = 1'b1; o_k_len = 10'd2; o_n_dots = 16'd1;
    @(negedge clk);
    o_start = 1'b0; o_in_valid = 1'b1; o_in_data = '1;
    repeat (2) @(negedge clk);
    o_in_valid = 1'b0;
    #1;
    check("ovf_out_valid", o_out_valid, 1);
    check("ovf_out_data", o_out_data, 67108862);
    check("ovf_flag", o_overflow, 1);
    @(negedge clk);
    #1;
    check("ovf_done", o_done, 1);
    check("ovf_busy", o_busy, 0);
    @(negedge clk);
    o_start = 1'b1; o_k_len = 10'd1; o_n_dots = 16'd1;
    @(negedge clk);
    o_start = 1'b0;
    #1;
    check("ovf_cleared_by_start", o_overflow, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
